if_buffer: RTL and testbench

IF_BUFFER -- requirements
Module: if_buffer

---
 rtl/if_buffer.sv | 103 ++++++++++
 tb/tb_if_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/if_buffer.sv
// Fetch-to-decode skid FIFO of {PC, Instruction} pairs with flush on Branch.
// Ports: clk, rst, PC, Instruction, Branch, ID_Ready in; PCWrite, ID_Valid,
// ID_PC, ID_Instruction out; StallCycles/FlushCount with IF_BUFFER_STATS_EN.
module if_buffer #(
  parameter int DEPTH  = 2,
  parameter int PC_W   = 12,
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   PC,
  input  logic [INST_W-1:0] Instruction,
  input  logic              Branch,
  output logic              PCWrite,
  input  logic              ID_Ready,
  output logic              ID_Valid,
  output logic [PC_W-1:0]   ID_PC,
  output logic [INST_W-1:0] ID_Instruction
`ifdef IF_BUFFER_STATS_EN
  ,
  output logic [15:0]       StallCycles,
  output logic [15:0]       FlushCount
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];

  logic [PTR_W-1:0] wr;
  logic [PTR_W-1:0] rd;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == FULL);
  assign empty = (count == '0);

  // Full blocks push even when a pop frees a slot this edge.
  assign push = !full && !Branch;
  assign pop  = !empty && ID_Ready && !Branch;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      (push && !pop): count_nxt = count + 1'b1;
      (pop && !push): count_nxt = count - 1'b1;
      default:        count_nxt = count;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap by overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else if (Branch) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr]   <= PC;
      mem_inst[wr] <= Instruction;
    end
  end

  assign PCWrite        = !full || Branch;
  assign ID_Valid       = !empty;
  assign ID_PC          = empty ? '0 : mem_pc[rd];
  assign ID_Instruction = empty ? NOP_INST : mem_inst[rd];

`ifdef IF_BUFFER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (full && !Branch && StallCycles != 16'hFFFF)
        StallCycles <= StallCycles + 16'd1;
      if (Branch && FlushCount != 16'hFFFF)
        FlushCount <= FlushCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_buffer.sv
// Scoreboard bench for if_buffer: fetch model, expected queue, monitor.
// Directed scenarios, async reset, then a long randomized run.
module tb_if_buffer;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [11:0] PC;
  logic [31:0] Instruction;
  logic        Branch;
  logic        PCWrite;
  logic        ID_Ready;
  logic        ID_Valid;
  logic [11:0] ID_PC;
  logic [31:0] ID_Instruction;
`ifdef IF_BUFFER_STATS_EN
  logic [15:0] StallCycles;
  logic [15:0] FlushCount;
`endif

  if_buffer dut (
    .clk(clk),
    .rst(rst),
    .PC(PC),
    .Instruction(Instruction),
    .Branch(Branch),
    .PCWrite(PCWrite),
    .ID_Ready(ID_Ready),
    .ID_Valid(ID_Valid),
    .ID_PC(ID_PC),
    .ID_Instruction(ID_Instruction)
`ifdef IF_BUFFER_STATS_EN
    ,
    .StallCycles(StallCycles),
    .FlushCount(FlushCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [43:0] q[$];
  int          cnt_m;
  int          stall_m;
  int          flush_m;
  logic [11:0] fetch_pc;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [11:0] p);
    return {8'hA5, 12'h000, p};
  endfunction

  task automatic chk_stats();
`ifdef IF_BUFFER_STATS_EN
    chk("stall_cycles", 64'(StallCycles), 64'(stall_m));
    chk("flush_count", 64'(FlushCount), 64'(flush_m));
`endif
  endtask

  // Monitor: compare head against scoreboard, pop on accepted handshake.
  always @(negedge clk) begin
    logic [43:0] e;
    if (!rst) begin
      chk("id_valid", 64'(ID_Valid), 64'(q.size() != 0));
      chk("pcwrite", 64'(PCWrite),
          64'((q.size() != DEPTH) || Branch));
      if (q.size() == 0) begin
        chk("empty_pc", 64'(ID_PC), 64'h0);
        chk("empty_inst", 64'(ID_Instruction), 64'(NOP));
      end else begin
        e = q[0];
        chk("head_pc", 64'(ID_PC), 64'(e[43:32]));
        chk("head_inst", 64'(ID_Instruction), 64'(e[31:0]));
        if (ID_Ready && !Branch) void'(q.pop_front());
      end
    end
  end

  task automatic step(input logic rdy, input logic br,
                      input logic [11:0] tgt);
    logic pcw;
    logic push_ok;
    logic pop_ok;
    ID_Ready    = rdy;
    Branch      = br;
    PC          = fetch_pc;
    Instruction = inst_of(fetch_pc);
    @(negedge clk);
    #1;
    pcw     = PCWrite;
    push_ok = (cnt_m != DEPTH) && !br;
    pop_ok  = (cnt_m != 0) && rdy && !br;
    if (br) begin
      q.delete();
      cnt_m = 0;
      flush_m++;
    end else begin
      if (cnt_m == DEPTH) stall_m++;
      if (push_ok) q.push_back({PC, Instruction});
      cnt_m = cnt_m + int'(push_ok) - int'(pop_ok);
    end
    @(posedge clk);
    if (pcw) fetch_pc = br ? tgt : fetch_pc + 12'd4;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ID_Ready = 1'b0;
    Branch = 1'b0;
    fetch_pc = '0;
    PC = '0;
    Instruction = inst_of('0);
    cnt_m = 0;
    stall_m = 0;
    flush_m = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(ID_Valid), 64'h0);
    chk("rst_pcwrite", 64'(PCWrite), 64'h1);
    chk("rst_pc", 64'(ID_PC), 64'h0);
    chk("rst_inst", 64'(ID_Instruction), 64'(NOP));
    chk_stats();
    rst = 1'b0;

    // Streaming: 0x000, 0x004, 0x008 one cycle later each.
    repeat (4) step(1'b1, 1'b0, 12'h0);

    // Flush to empty at 0x000, then stall with ready low.
    step(1'b1, 1'b1, 12'h000);
    repeat (4) step(1'b0, 1'b0, 12'h0);
    chk("held_fetch_pc", 64'(fetch_pc), 64'h008);
    chk_stats();

    // One pop from full, no push that edge.
    step(1'b1, 1'b0, 12'h0);
    chk("after_pop_pc", 64'(fetch_pc), 64'h008);
    step(1'b0, 1'b0, 12'h0);

    // Flush with two buffered, ready high.
    step(1'b1, 1'b1, 12'h100);
    step(1'b0, 1'b0, 12'h0);
    chk_stats();
    step(1'b1, 1'b0, 12'h0);
    step(1'b1, 1'b0, 12'h0);

    // Fill to two entries, then async reset mid-cycle.
    repeat (3) step(1'b0, 1'b0, 12'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 64'(ID_Valid), 64'h0);
    chk("async_pcwrite", 64'(PCWrite), 64'h1);
    chk("async_inst", 64'(ID_Instruction), 64'(NOP));
    q.delete();
    cnt_m = 0;
    stall_m = 0;
    flush_m = 0;
    fetch_pc = 12'h040;
    chk_stats();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step(1'b1, 1'b0, 12'h0);

    // Long random run, many pointer wraps.
    for (int i = 0; i < 400; i++) begin
      logic [11:0] t;
      t = 12'($urandom_range(0, 1023) << 2);
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), t);
    end
    chk_stats();
    repeat (4) step(1'b1, 1'b0, 12'h0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
